ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, SHALL be the word-address width; depth = 2^ADDR_WIDTH words.
REQ-002 Parameter BYTES, default 4, SHALL be the bytes per word; DW = 8*BYTES.
REQ-003 Parameter LEN_WIDTH, default 4, SHALL be the burst-length field width.
REQ-004 clk_in  input  1  SHALL be the system clock; all logic is clocked on the rising edge.
REQ-005 rst_in  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-006 en_in  input  1  SHALL be the chip enable; when low, no new request is accepted.
REQ-007 req_valid  input  1  SHALL mean a request is presented.
REQ-008 req_ready  output  1  SHALL mean the block can accept a request this cycle.
REQ-009 req_we  input  1  SHALL select write (1) or read (0).
REQ-010 req_addr  input  ADDR_WIDTH  SHALL be the word address.
REQ-011 req_wdata  input  DW  SHALL be the write data; byte i is bits [8i+7:8i].
REQ-012 req_be  input  BYTES  SHALL be the per-byte write enables.
REQ-013 req_len  input  LEN_WIDTH  SHALL give read burst beats minus one.
REQ-014 rsp_valid  output  1  SHALL mark a valid read-data beat.
REQ-015 rsp_data  output  DW  SHALL be the read data.
REQ-016 rsp_last  output  1  SHALL mark the final beat of a read.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid, req_ready and en_in are all 1.
REQ-018 req_ready SHALL equal (state==IDLE) & en_in.
REQ-019 An accepted write SHALL update only the bytes with req_be[i]=1 at that edge; it produces no response beat.
REQ-020 req_be=0 on a write SHALL leave memory unchanged and still consume the request.
REQ-021 An accepted read SHALL produce its first beat with rsp_valid=1 exactly one cycle after acceptance.
REQ-022 A read issued the cycle after a write to the same address SHALL return the newly written bytes.
REQ-023 States SHALL be IDLE and BURST; IDLE->BURST on an accepted read with req_len>0; BURST->IDLE when the beat with rsp_last=1 is issued.
REQ-024 In BURST, one beat SHALL be issued per cycle at consecutive word addresses, (req_len+1) beats in total, with req_ready=0 throughout.
REQ-025 Burst addresses SHALL wrap modulo 2^ADDR_WIDTH (e.g. last word -> word 0).
REQ-026 rsp_last SHALL be 1 only on the final beat; a single-beat read (req_len=0) has rsp_last=1 on its only beat.
REQ-027 Back-to-back single reads SHALL sustain one accept and one beat per cycle.
REQ-028 Responses SHALL have no backpressure; a consumer must take each beat in the cycle it is presented.
REQ-029 rsp_data SHALL be all zeros whenever rsp_valid=0.
REQ-030 en_in falling during BURST SHALL NOT stall the burst; it only blocks new acceptance.
REQ-031 req_len SHALL be ignored on writes.

Reset
REQ-032 With rst_in=1 at an edge: state=IDLE, rsp_valid=0, rsp_last=0, rsp_data=0, and the burst counter and address are cleared.
REQ-033 Reset during a burst SHALL abort it; no further beats are issued.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 req_ready SHALL be 0 while rst_in=1.

Configuration
REQ-036 With RAM_CTRL_BURST_EN defined, the burst behaviour of REQ-023..REQ-026 SHALL be included.
REQ-037 Without RAM_CTRL_BURST_EN, req_len SHALL be ignored, every read SHALL be a single beat with rsp_last=1, and BURST SHALL never be entered.

Verification
REQ-038 Write 0xDEADBEEF at addr 5 with be=4'hF, then read addr 5 -> one cycle later rsp_valid=1, rsp_data=0xDEADBEEF, rsp_last=1.
REQ-039 Write 0x11223344 at addr 7, then write 0xAABBCCDD at addr 7 with be=4'b0101, then read addr 7 -> 0x11BB33DD.
REQ-040 With BURST_EN, read addr 2^ADDR_WIDTH-2 with len=3 -> 4 consecutive beats from words 0x7FFE, 0x7FFF, 0, 1; rsp_last on the 4th beat only; req_ready=0 until the last beat.
REQ-041 Reset asserted on the 2nd beat of an 8-beat burst -> rsp_valid=0 on the next cycle and thereafter; req_ready=1 one cycle after rst_in falls.
REQ-042 Single reads at addrs 0,1,2 on consecutive cycles -> three beats on consecutive cycles, each with rsp_last=1; with en_in=0, req_valid=1 -> no acceptance and no beat.
REQ-043 Without BURST_EN, read with len=5 -> exactly one beat with rsp_last=1.

Source files
------------

// File: rtl/ram_ctrl.sv
// Byte-enabled single-port word RAM with a request/response front end and optional read bursts.
// Define RAM_CTRL_BURST_EN to enable multi-beat reads driven by req_len; otherwise every read is one beat.
module ram_ctrl #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned BYTES      = 4,
   parameter int unsigned LEN_WIDTH  = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    en_in,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [8*BYTES-1:0]      req_wdata,
   input  logic [BYTES-1:0]        req_be,
   input  logic [LEN_WIDTH-1:0]    req_len,
   output logic                    rsp_valid,
   output logic [8*BYTES-1:0]      rsp_data,
   output logic                    rsp_last
);

   localparam int unsigned DW    = 8 * BYTES;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

`ifdef RAM_CTRL_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   logic [DW-1:0]         mem [DEPTH];

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  left_q, left_d;
   logic                  rsp_valid_d, rsp_last_d;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  accept, wr_en, burst_start;

   assign req_ready   = (state_q == S_IDLE) & en_in & ~rst_in;
   assign accept      = req_valid & req_ready;
   assign wr_en       = accept & req_we;
   assign burst_start = BURST_EN & accept & ~req_we & (req_len != '0);

   // Next-state and next-beat selection
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      left_d      = left_q;
      rsp_valid_d = 1'b0;
      rsp_last_d  = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = req_addr;
      case (state_q)
         S_IDLE: begin
            if (accept && !req_we) begin
               rd_en       = 1'b1;
               rsp_valid_d = 1'b1;
               if (burst_start) begin
                  state_d = S_BURST;
                  addr_d  = ADDR_WIDTH'(req_addr + 1'b1);
                  left_d  = req_len;
               end else begin
                  rsp_last_d = 1'b1;
               end
            end
         end
         S_BURST: begin
            // left_q counts beats still owed after the one already issued
            rd_en       = 1'b1;
            rd_addr     = addr_q;
            rsp_valid_d = 1'b1;
            addr_d      = ADDR_WIDTH'(addr_q + 1'b1);
            left_d      = LEN_WIDTH'(left_q - 1'b1);
            if (left_q == LEN_WIDTH'(1)) begin
               rsp_last_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state and response flags
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         left_q    <= '0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         left_q    <= left_d;
         rsp_valid <= rsp_valid_d;
         rsp_last  <= rsp_last_d;
      end
   end

   // Storage is not reset; only enabled bytes are written
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         for (int i = 0; i < BYTES; i++) begin
            if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   // Read data register, forced to zero on idle cycles
   always_ff @(posedge clk_in) begin
      if (rst_in)     rsp_data <= '0;
      else if (rd_en) rsp_data <= mem[rd_addr];
      else            rsp_data <= '0;
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed vector table, burst/reset sequences and a random run
// against a queue-of-beats reference model. Honours RAM_CTRL_BURST_EN like the design.
module tb_ram_ctrl;

   localparam int unsigned AW    = 15;
   localparam int unsigned NB    = 4;
   localparam int unsigned LW    = 4;
   localparam int unsigned DEPTH = 1 << AW;

`ifdef RAM_CTRL_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, en, valid, we;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [NB-1:0] be;
   logic [LW-1:0] len;
   logic          req_ready, rsp_valid, rsp_last;
   logic [31:0]   rsp_data;

   int n_chk  = 0;
   int n_fail = 0;
   logic ready_s;

   always #5 clk = ~clk;

   ram_ctrl #(.ADDR_WIDTH(AW), .BYTES(NB), .LEN_WIDTH(LW)) dut (
      .clk_in(clk), .rst_in(rst), .en_in(en), .req_valid(valid), .req_ready(req_ready),
      .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_be(be), .req_len(len),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last)
   );

   // Reference model: an accepted read enqueues all of its beats; one beat leaves per cycle.
   typedef struct packed { logic [AW-1:0] a; logic last; } beat_t;
   logic [31:0] mdl_mem [DEPTH];
   beat_t       pend [$];
   logic        x_valid = 1'b0, x_last = 1'b0;
   logic [31:0] x_data = '0;

   always @(posedge clk) begin
      beat_t b;
      int n;
      x_valid = 1'b0; x_last = 1'b0; x_data = '0;
      if (rst) begin
         pend.delete();
      end else begin
         if (pend.size() == 0 && en && valid) begin
            if (we) begin
               for (int i = 0; i < 4; i++) if (be[i]) mdl_mem[addr][8*i +: 8] = wdata[8*i +: 8];
            end else begin
               n = (BURST_EN && len != 0) ? int'(len) + 1 : 1;
               for (int k = 0; k < n; k++) pend.push_back('{a: AW'(int'(addr) + k), last: (k == n - 1)});
            end
         end
         if (pend.size() > 0) begin
            b = pend.pop_front();
            x_valid = 1'b1; x_data = mdl_mem[b.a]; x_last = b.last;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive, check ready before the edge, check the beat after it against the model
   task automatic cycle(input logic r, input logic e, input logic v, input logic w,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [NB-1:0] b, input logic [LW-1:0] l);
      rst = r; en = e; valid = v; we = w; addr = a; wdata = d; be = b; len = l;
      #1;
      ready_s = req_ready;
      chk("model req_ready", req_ready, !r && e && pend.size() == 0);
      @(posedge clk); #1;
      chk("model rsp_valid", rsp_valid, x_valid);
      chk("model rsp_data",  rsp_data,  x_data);
      chk("model rsp_last",  rsp_last,  x_last);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [LW-1:0] l);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, a, '0, '0, l);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [NB-1:0] b);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, a, d, b, '0);
   endtask

   task automatic beat(input string name, input logic v, input logic [31:0] d, input logic l);
      chk({name, " valid"}, rsp_valid, v);
      chk({name, " data"},  rsp_data,  d);
      chk({name, " last"},  rsp_last,  l);
   endtask

   typedef struct {
      logic en, valid, we;
      logic [AW-1:0] a; logic [31:0] d; logic [NB-1:0] b; logic [LW-1:0] l;
      logic x_rdy, x_v; logic [31:0] x_d; logic x_l;
   } vec_t;

   function automatic vec_t mk(input logic e, input logic v, input logic w, input logic [AW-1:0] a,
                               input logic [31:0] d, input logic [NB-1:0] b, input logic [LW-1:0] l,
                               input logic xr, input logic xv, input logic [31:0] xd, input logic xl);
      vec_t t;
      t.en = e; t.valid = v; t.we = w; t.a = a; t.d = d; t.b = b; t.l = l;
      t.x_rdy = xr; t.x_v = xv; t.x_d = xd; t.x_l = xl;
      return t;
   endfunction

   vec_t tbl [17];

   initial begin
      tbl[0]  = mk(1, 1, 1, 5, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 0);
      tbl[1]  = mk(1, 1, 0, 5, 0,            4'h0, 0, 1, 1, 32'hDEADBEEF, 1);
      tbl[2]  = mk(1, 1, 1, 7, 32'h11223344, 4'hF, 0, 1, 0, 0, 0);
      tbl[3]  = mk(1, 1, 1, 7, 32'hAABBCCDD, 4'h5, 0, 1, 0, 0, 0);
      tbl[4]  = mk(1, 1, 0, 7, 0,            4'h0, 0, 1, 1, 32'h11BB33DD, 1);
      tbl[5]  = mk(1, 1, 1, 9, 32'h12345678, 4'hF, 7, 1, 0, 0, 0);
      tbl[6]  = mk(1, 1, 1, 9, 32'hFFFFFFFF, 4'h0, 0, 1, 0, 0, 0);
      tbl[7]  = mk(1, 1, 0, 9, 0,            4'h0, 0, 1, 1, 32'h12345678, 1);
      tbl[8]  = mk(1, 1, 1, 0, 32'hA0A0A0A0, 4'hF, 0, 1, 0, 0, 0);
      tbl[9]  = mk(1, 1, 1, 1, 32'hB1B1B1B1, 4'hF, 0, 1, 0, 0, 0);
      tbl[10] = mk(1, 1, 1, 2, 32'hC2C2C2C2, 4'hF, 0, 1, 0, 0, 0);
      tbl[11] = mk(1, 1, 0, 0, 0,            4'h0, 0, 1, 1, 32'hA0A0A0A0, 1);
      tbl[12] = mk(1, 1, 0, 1, 0,            4'h0, 0, 1, 1, 32'hB1B1B1B1, 1);
      tbl[13] = mk(1, 1, 0, 2, 0,            4'h0, 0, 1, 1, 32'hC2C2C2C2, 1);
      tbl[14] = mk(0, 1, 0, 5, 0,            4'h0, 0, 0, 0, 0, 0);
      tbl[15] = mk(0, 1, 1, 5, 32'h0,        4'hF, 0, 0, 0, 0, 0);
      tbl[16] = mk(1, 1, 0, 5, 0,            4'h0, 0, 1, 1, 32'hDEADBEEF, 1);

      // Reset state
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
      chk("reset req_ready", ready_s, 1'b0);
      beat("reset", 1'b0, 32'h0, 1'b0);

      // Known contents for every address the random run can reach
      for (int i = 0; i < 32; i++) wr(AW'(i), $urandom, 4'hF);
      for (int i = 0; i < 16; i++) wr(AW'(DEPTH - 16 + i), $urandom, 4'hF);

      foreach (tbl[i]) begin
         cycle(1'b0, tbl[i].en, tbl[i].valid, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].l);
         chk($sformatf("vec%0d req_ready", i), ready_s, tbl[i].x_rdy);
         beat($sformatf("vec%0d", i), tbl[i].x_v, tbl[i].x_d, tbl[i].x_l);
      end
      idle();

`ifdef RAM_CTRL_BURST_EN
      // Wrapping 4-beat burst; a competing read stays blocked until the last beat
      wr(AW'(DEPTH - 2), 32'h00007FFE, 4'hF);
      wr(AW'(DEPTH - 1), 32'h00007FFF, 4'hF);
      wr(AW'(0),         32'h10000000, 4'hF);
      wr(AW'(1),         32'h10000001, 4'hF);
      rd(AW'(DEPTH - 2), 4'd3);
      beat("wrap b1", 1'b1, 32'h00007FFE, 1'b0);
      rd(AW'(3), 4'd0);
      chk("wrap ready b1", ready_s, 1'b0);
      beat("wrap b2", 1'b1, 32'h00007FFF, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, AW'(3), '0, '0, '0);
      chk("wrap ready b2", ready_s, 1'b0);
      beat("wrap b3", 1'b1, 32'h10000000, 1'b0);
      rd(AW'(3), 4'd0);
      chk("wrap ready b3", ready_s, 1'b0);
      beat("wrap b4", 1'b1, 32'h10000001, 1'b1);
      idle();
      chk("wrap ready after", ready_s, 1'b1);
      beat("wrap done", 1'b0, 32'h0, 1'b0);

      // Reset on the second beat of an 8-beat burst
      rd(AW'(0), 4'd7);
      beat("abort b1", 1'b1, 32'h10000000, 1'b0);
      idle();
      beat("abort b2", 1'b1, 32'h10000001, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
      chk("abort ready in reset", ready_s, 1'b0);
      beat("abort rst", 1'b0, 32'h0, 1'b0);
      idle();
      beat("abort post1", 1'b0, 32'h0, 1'b0);
      idle();
      chk("abort ready post", ready_s, 1'b1);
      beat("abort post2", 1'b0, 32'h0, 1'b0);
`else
      // req_len is ignored: a single beat
      wr(AW'(12), 32'hCAFEF00D, 4'hF);
      rd(AW'(12), 4'd5);
      beat("len5 beat", 1'b1, 32'hCAFEF00D, 1'b1);
      idle();
      chk("len5 ready", ready_s, 1'b1);
      beat("len5 post1", 1'b0, 32'h0, 1'b0);
      idle();
      beat("len5 post2", 1'b0, 32'h0, 1'b0);
`endif

      // Memory survives reset
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
      rd(AW'(7), 4'd0);
      beat("post-reset mem", 1'b1, 32'h11BB33DD, 1'b1);
      idle();

      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         logic [AW-1:0] ra;
         ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                          : AW'(DEPTH - 8 + $urandom_range(0, 7));
         cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1), ra,
               $urandom, NB'($urandom), LW'($urandom));
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
